// File: rtl/out_port_queue.sv
// Output-port byte queue: FWFT FIFO with packet-aware read framing and oversize drop.
// Define OUT_PORT_CUT_THROUGH_EN for cut-through delivery (no oversize detection).
module out_port_queue #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] wr_data,
  input  logic       wr_last,
  input  logic       wr_valid,
  output logic       wr_ready,
  output logic [7:0] port_out,
  output logic       port_ready,
  input  logic       port_read,
  output logic       oversize
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {R_IDLE, R_SEND, R_GAP} rd_state_t;
  typedef enum logic       {W_ACCEPT, W_DROP}      wr_state_t;

  logic [8:0]  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] pkt_cnt_q, pkt_cnt_d;
  rd_state_t   rd_state_q, rd_state_d;
  wr_state_t   wr_state_q, wr_state_d;

  logic [8:0]  head;
  logic        full, empty, flush;
  logic        do_write, do_store, do_pop, head_last;

  assign head      = mem_q[rd_ptr_q[AW-1:0]];
  assign head_last = head[8];
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  always_comb begin
`ifdef OUT_PORT_CUT_THROUGH_EN
    port_ready = !rst && (rd_state_q == R_SEND) && !empty;
    flush      = 1'b0;
    wr_ready   = !rst && !full;
`else
    port_ready = !rst && (rd_state_q == R_SEND);
    // A full FIFO holding no complete packet can never drain: discard it.
    flush      = (wr_state_q == W_ACCEPT) && full && (pkt_cnt_q == '0);
    wr_ready   = !rst && ((wr_state_q == W_DROP) || !full);
`endif
    oversize   = !rst && flush;
    port_out   = port_ready ? head[7:0] : 8'h00;
    do_write   = wr_valid && wr_ready;
    do_store   = do_write && (wr_state_q == W_ACCEPT);
    do_pop     = port_ready && port_read;
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q + (AW+1)'(do_store);
    rd_ptr_d  = rd_ptr_q + (AW+1)'(do_pop);
    pkt_cnt_d = pkt_cnt_q;
    case ({do_store && wr_last, do_pop && head_last})
      2'b10:   pkt_cnt_d = pkt_cnt_q + 1'b1;
      2'b01:   pkt_cnt_d = pkt_cnt_q - 1'b1;
      default: pkt_cnt_d = pkt_cnt_q;
    endcase
    if (flush) begin
      rd_ptr_d  = wr_ptr_q;
      pkt_cnt_d = '0;
    end
  end

  always_comb begin
    wr_state_d = wr_state_q;
`ifndef OUT_PORT_CUT_THROUGH_EN
    case (wr_state_q)
      W_ACCEPT: if (flush) wr_state_d = W_DROP;
      W_DROP:   if (do_write && wr_last) wr_state_d = W_ACCEPT;
      default:  wr_state_d = W_ACCEPT;
    endcase
`endif
  end

  // IDLE looks at next-cycle occupancy so delivery starts the cycle after the enabling write.
  always_comb begin
    rd_state_d = rd_state_q;
    case (rd_state_q)
`ifdef OUT_PORT_CUT_THROUGH_EN
      R_IDLE:  if (wr_ptr_d != rd_ptr_d) rd_state_d = R_SEND;
`else
      R_IDLE:  if (pkt_cnt_d != '0) rd_state_d = R_SEND;
`endif
      R_SEND:  if (do_pop && head_last) rd_state_d = R_GAP;
      R_GAP:   rd_state_d = R_IDLE;
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pkt_cnt_q  <= '0;
      rd_state_q <= R_IDLE;
      wr_state_q <= W_ACCEPT;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pkt_cnt_q  <= pkt_cnt_d;
      rd_state_q <= rd_state_d;
      wr_state_q <= wr_state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_store) mem_q[wr_ptr_q[AW-1:0]] <= {wr_last, wr_data};
  end

endmodule

// File: tb/tb_out_port_queue.sv
// Directed bench for out_port_queue (store-and-forward build) with a queue-based reference model.
module tb_out_port_queue;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] wr_data;
  logic       wr_last, wr_valid, wr_ready;
  logic [7:0] port_out;
  logic       port_ready, port_read, oversize;

  int n_checks = 0;
  int n_fail   = 0;

  out_port_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_last(wr_last), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .port_out(port_out), .port_ready(port_ready),
    .port_read(port_read), .oversize(oversize)
  );

  always #5 clk = ~clk;

  // Reference model: byte queue, packet-in-flight flag, post-packet holdoff, drop mode.
  logic [8:0] mq[$];
  bit         m_sending = 0;
  int         m_holdoff = 0;
  bit         m_drop    = 0;

  function automatic bit has_last();
    foreach (mq[i]) if (mq[i][8]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit exp_wr_ready();
    return !rst && (m_drop || (mq.size() < DEPTH));
  endfunction

  function automatic bit exp_oversize();
    return !rst && !m_drop && (mq.size() == DEPTH) && !has_last();
  endfunction

  function automatic bit exp_port_ready();
    return !rst && m_sending;
  endfunction

  function automatic logic [7:0] exp_port_out();
    return exp_port_ready() ? mq[0][7:0] : 8'h00;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_sending = 0;
      m_holdoff = 0;
      m_drop    = 0;
    end else begin
      bit acc, pop, pop_last;
      acc      = wr_valid && exp_wr_ready();
      pop      = m_sending && port_read;
      pop_last = pop && mq[0][8];
      if (exp_oversize()) begin
        mq.delete();
        m_drop = 1;
      end else begin
        if (pop) void'(mq.pop_front());
        if (acc) begin
          if (m_drop) begin
            if (wr_last) m_drop = 0;
          end else begin
            mq.push_back({wr_last, wr_data});
          end
        end
      end
      if (pop_last) begin
        m_sending = 0;
        m_holdoff = 1;
      end else if (!m_sending) begin
        if (m_holdoff > 0) m_holdoff--;
        else if (has_last()) m_sending = 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("wr_ready", wr_ready, exp_wr_ready());
    chk("oversize", oversize, exp_oversize());
    chk("port_ready", port_ready, exp_port_ready());
    chk("port_out", port_out, exp_port_out());
  end

  task automatic drive(input bit v, input bit l, input logic [7:0] d, input bit r);
    wr_valid  = v;
    wr_last   = l;
    wr_data   = d;
    port_read = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 8'h00, 0);
    repeat (3) tick();
    chk("rst_port_ready", port_ready, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_port_out", port_out, 0);
    rst = 1'b0;
    #1;
    chk("wr_ready_after_rst", wr_ready, 1);

    // 3-byte packet with port_read held high
    drive(1, 0, 8'hA1, 1); tick();
    drive(1, 0, 8'hA2, 1); tick();
    drive(1, 1, 8'hA3, 1); tick();
    chk("t1_ready", port_ready, 1);
    chk("t1_b1", port_out, 8'hA1);
    drive(0, 0, 8'h00, 1); tick();
    chk("t1_b2", port_out, 8'hA2);
    tick();
    chk("t1_b3", port_out, 8'hA3);
    tick();
    chk("t1_gap", port_ready, 0);
    tick();
    chk("t1_idle", port_ready, 0);
    repeat (2) tick();

    // two 2-byte packets held back for 10 cycles
    drive(1, 0, 8'hB1, 0); tick();
    drive(1, 1, 8'hB2, 0); tick();
    drive(1, 0, 8'hC1, 0); tick();
    drive(1, 1, 8'hC2, 0); tick();
    drive(0, 0, 8'h00, 0);
    repeat (6) tick();
    chk("t2_pkt_cnt", dut.pkt_cnt_q, 2);
    chk("t2_ready", port_ready, 1);
    chk("t2_head", port_out, 8'hB1);
    drive(0, 0, 8'h00, 1); tick();
    chk("t2_b2", port_out, 8'hB2);
    tick();
    chk("t2_gap", port_ready, 0);
    tick();
    chk("t2_idle", port_ready, 0);
    tick();
    chk("t2_c1", port_out, 8'hC1);
    repeat (4) tick();

    // oversize: 16 bytes without last, then 4 dropped bytes, then 8'h55
    for (int i = 0; i < 16; i++) begin
      drive(1, 0, 8'(8'h10 + i), 0); tick();
    end
    chk("t3_oversize", oversize, 1);
    chk("t3_full_wr_ready", wr_ready, 0);
    drive(1, 0, 8'h20, 0); tick();
    chk("t3_pulse_end", oversize, 0);
    chk("t3_drop_ready", wr_ready, 1);
    chk("t3_flushed", dut.pkt_cnt_q, 0);
    tick();
    drive(1, 0, 8'h21, 0); tick();
    drive(1, 0, 8'h22, 0); tick();
    drive(1, 1, 8'h23, 0); tick();
    chk("t3_no_ready", port_ready, 0);
    drive(1, 1, 8'h55, 0); tick();
    chk("t3_55_ready", port_ready, 1);
    chk("t3_55", port_out, 8'h55);
    drive(0, 0, 8'h00, 1); tick();
    chk("t3_done", port_ready, 0);
    repeat (3) tick();

    // full FIFO with packets queued: simultaneous write attempt and pop
    for (int i = 0; i < 16; i++) begin
      drive(1, (i % 4) == 3, 8'(8'h40 + i), 0); tick();
    end
    chk("t4_full", wr_ready, 0);
    chk("t4_no_oversize", oversize, 0);
    chk("t4_head", port_out, 8'h40);
    drive(1, 1, 8'h99, 1);
    #1;
    chk("t4_blocked", wr_ready, 0);
    tick();
    chk("t4_ready_again", wr_ready, 1);
    chk("t4_popped", port_out, 8'h41);
    drive(1, 1, 8'h99, 0); tick();
    drive(0, 0, 8'h00, 1);
    repeat (30) tick();
    chk("t4_drained", port_ready, 0);
    chk("t4_cnt", dut.pkt_cnt_q, 0);

    // reset during byte 2 of a 5-byte packet, with a complete packet already queued
    drive(1, 1, 8'h5A, 0); tick();
    drive(1, 0, 8'h61, 0); tick();
    chk("t5_pre_ready", port_ready, 1);
    rst = 1'b1;
    drive(1, 0, 8'h62, 0); tick();
    rst = 1'b0;
    drive(0, 0, 8'h00, 0);
    #1;
    chk("t5_ready", port_ready, 0);
    chk("t5_cnt", dut.pkt_cnt_q, 0);
    chk("t5_oversize", oversize, 0);
    chk("t5_wr_ready", wr_ready, 1);
    drive(1, 0, 8'h71, 1); tick();
    drive(1, 1, 8'h72, 1); tick();
    chk("t5_b1", port_out, 8'h71);
    drive(0, 0, 8'h00, 1); tick();
    chk("t5_b2", port_out, 8'h72);
    tick();
    chk("t5_end", port_ready, 0);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/out_port_queue.md
OUT_PORT_QUEUE -- requirements
Module: out_port_queue

Interface
REQ-001 Parameter DEPTH SHALL default to 16 and set the FIFO entry count; legal values are powers of two from 4 to 256.
REQ-002 clk  input  1  single clock; every flop SHALL be updated on its rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 wr_data  input  8  byte from the switch fabric.
REQ-005 wr_last  input  1  marks wr_data as the final byte of a packet.
REQ-006 wr_valid  input  1  wr_data and wr_last are valid this cycle.
REQ-007 wr_ready  output  1  the queue accepts a byte this cycle.
REQ-008 port_out  output  8  serial 1-byte output data.
REQ-009 port_ready  output  1  port_out holds a valid byte.
REQ-010 port_read  input  1  the consumer takes port_out this cycle.
REQ-011 oversize  output  1  one-cycle pulse when a packet is discarded for exceeding DEPTH.

Function
REQ-012 A write SHALL occur on a rising edge when wr_valid=1 and wr_ready=1; each FIFO entry SHALL store {wr_last, wr_data}.
REQ-013 wr_ready SHALL equal NOT full, except in DROP state, where it SHALL be 1.
REQ-014 The FIFO SHALL be first-word-fall-through: while port_ready=1, port_out SHALL present the head entry combinationally.
REQ-015 A pop SHALL occur on a rising edge when port_ready=1 and port_read=1; the next byte SHALL be visible the following cycle.
REQ-016 port_read SHALL be ignored while port_ready=0.
REQ-017 A write and a pop in the same cycle SHALL both complete, leaving occupancy unchanged.
REQ-018 pkt_cnt, of width log2(DEPTH)+1, SHALL count complete packets held in the FIFO:
  - +1 on a write with wr_last=1;
  - -1 on a pop of an entry with last=1;
  - unchanged when both occur in the same cycle.
REQ-019 The read FSM SHALL have states IDLE, SEND and GAP:
  - IDLE: port_ready=0; go to SEND when pkt_cnt>0.
  - SEND: port_ready=1; go to GAP on a pop of a last=1 entry.
  - GAP: port_ready=0 for exactly one cycle, then go to IDLE.
REQ-020 Packets SHALL therefore be separated by at least two port_ready-low cycles (GAP, then IDLE); port_ready SHALL never deassert mid-packet in store-and-forward mode.
REQ-021 The write FSM SHALL have states ACCEPT and DROP.
REQ-022 In ACCEPT, if full=1 and pkt_cnt=0 (the partial packet cannot complete):
  - pulse oversize for one cycle;
  - flush the FIFO (pointers equal, pkt_cnt=0);
  - enter DROP.
REQ-023 In DROP, every byte offered SHALL be accepted and discarded; a discarded byte with wr_last=1 SHALL return the write FSM to ACCEPT.
REQ-024 Pointers SHALL wrap modulo DEPTH; full and empty SHALL be distinguished by an extra pointer MSB.

Reset
REQ-025 While rst=1 at a rising edge, the block SHALL clear both pointers and pkt_cnt, and set the read FSM to IDLE and the write FSM to ACCEPT.
REQ-026 While rst=1, outputs SHALL be port_ready=0, port_out=8'h00, oversize=0, wr_ready=0.
REQ-027 wr_ready SHALL rise in the first cycle after rst deasserts.
REQ-028 rst asserted mid-packet SHALL discard all queued and partial data with no oversize pulse.

Configuration
REQ-029 With OUT_PORT_CUT_THROUGH_EN defined:
  - SEND SHALL be entered when the FIFO is non-empty;
  - port_ready SHALL equal NOT empty while in SEND and may drop mid-packet on underrun;
  - oversize detection and DROP SHALL be removed, with oversize tied to 0.
REQ-030 Without OUT_PORT_CUT_THROUGH_EN, store-and-forward per REQ-018 to REQ-023 SHALL apply.

Verification
REQ-031 Write 3-byte packet 8'hA1, 8'hA2, 8'hA3 (last on 8'hA3), port_read held 1 -> port_ready rises the cycle after the 8'hA3 write; port_out reads A1, A2, A3 on consecutive cycles; port_ready then stays 0 for 2 cycles.
REQ-032 Two back-to-back 2-byte packets with port_read=0 for 10 cycles -> pkt_cnt=2, port_ready=1 presenting byte 1 of packet 1, no bytes lost once reads resume.
REQ-033 DEPTH=16: write 16 bytes with no wr_last -> oversize pulses once, FIFO empties, the 17th through 20th bytes (last on the 20th) are accepted and dropped, and a following 1-byte packet 8'h55 emerges intact.
REQ-034 FIFO full with packets queued, wr_valid=1 and port_read=1 in the same cycle -> wr_ready=0 and the pop completes; the write is accepted the next cycle.
REQ-035 rst=1 for 1 cycle during byte 2 of a 5-byte packet -> port_ready=0 and pkt_cnt=0 the next cycle, oversize stays 0, and the next packet is delivered correctly.
REQ-036 With OUT_PORT_CUT_THROUGH_EN defined, write one byte 8'h7E without wr_last -> port_ready=1 the following cycle.
